// File: rtl/swnet_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : swnet_ctrl                                                 |
// | Description : SWNET store request queue between the core and the NI      |
// |               write FIFO: in-order forwarding, core back-pressure,       |
// |               stall statistics and a sticky NI-blocked timeout flag.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module swnet_ctrl #(
   parameter int MSB_SLOT = 5,
   parameter int QADDR    = 2,
   parameter int TIMEOUT  = 255,
   localparam int RSIZE   = 1 << (MSB_SLOT - 1)
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             core_swnet_valid_i,
   input  logic [RSIZE-1:0] core_wdata_i,
   input  logic [RSIZE-1:0] core_waddr_i,
   output logic             core_stall_o,
   input  logic             ni_wfull_i,
   output logic             ni_winc_o,
   output logic [RSIZE-1:0] ni_wdata_o,
   output logic [RSIZE-1:0] ni_waddr_o,
   output logic [15:0]      stall_cnt_o,
   output logic             err_timeout_o
);

   localparam int          DSIZE       = 1 << MSB_SLOT;
   localparam int          QDEPTH      = 1 << QADDR;
   localparam logic [15:0] TIMEOUT_W16 = TIMEOUT[15:0];

   // Occupancy tracker: IDLE always coincides with an empty queue because
   // both are computed from the same post-update pointers.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND    = 2'd1,
      BLOCKED = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [QADDR:0]     wr_ptr_q, wr_ptr_d;
   logic [QADDR:0]     rd_ptr_q, rd_ptr_d;
   logic [15:0]        blk_cnt_q, blk_cnt_d;
   logic [15:0]        stall_cnt_q, stall_cnt_d;
   logic               err_q, err_d;
   logic [DSIZE-1:0]   mem_q [QDEPTH];

   logic               w_full;
   logic               w_empty;
   logic               w_has_data;
   logic               w_enq;
   logic               w_deq;
   logic               w_blocked;
   logic [DSIZE-1:0]   w_head;

   // Queue status, handshakes and head-of-queue data.
   always_comb begin
      w_empty    = (wr_ptr_q == rd_ptr_q);
      w_full     = (wr_ptr_q[QADDR] != rd_ptr_q[QADDR]) &&
                   (wr_ptr_q[QADDR-1:0] == rd_ptr_q[QADDR-1:0]);
      w_has_data = (state_q != IDLE);
      // Enqueue looks only at the current full flag, so a same-cycle
      // dequeue never makes room for the incoming request.
      w_enq      = core_swnet_valid_i && !w_full;
      w_deq      = w_has_data && !ni_wfull_i;
      w_blocked  = !w_empty && ni_wfull_i;
      w_head     = mem_q[rd_ptr_q[QADDR-1:0]];

      core_stall_o  = core_swnet_valid_i && w_full;
      ni_winc_o     = w_deq;
      ni_waddr_o    = w_empty ? '0 : w_head[DSIZE-1:RSIZE];
      ni_wdata_o    = w_empty ? '0 : w_head[RSIZE-1:0];
      stall_cnt_o   = stall_cnt_q;
      err_timeout_o = err_q;
   end

   // Next-state: pointers, occupancy state, blocked/stall counters, timeout.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      state_d     = state_q;
      blk_cnt_d   = 16'd0;
      stall_cnt_d = stall_cnt_q;
      err_d       = err_q;

      if (w_enq) begin
         wr_ptr_d = wr_ptr_q + {{QADDR{1'b0}}, 1'b1};
      end
      if (w_deq) begin
         rd_ptr_d = rd_ptr_q + {{QADDR{1'b0}}, 1'b1};
      end

      if (wr_ptr_d == rd_ptr_d) begin
         state_d = IDLE;
      end else if (ni_wfull_i) begin
         state_d = BLOCKED;
      end else begin
         state_d = SEND;
      end

      if (w_blocked) begin
         blk_cnt_d = (blk_cnt_q == 16'hFFFF) ? blk_cnt_q : blk_cnt_q + 16'd1;
         if (blk_cnt_d == TIMEOUT_W16) begin
            err_d = 1'b1;
         end
      end

      if (core_stall_o && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         blk_cnt_q   <= 16'd0;
         stall_cnt_q <= 16'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         blk_cnt_q   <= blk_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         err_q       <= err_d;
      end
   end

   // Queue storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk_i) begin
      if (reset_ni && w_enq) begin
         mem_q[wr_ptr_q[QADDR-1:0]] <= {core_waddr_i, core_wdata_i};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_swnet_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_swnet_ctrl                                              |
// | Description : Self-checking bench for swnet_ctrl with a queue-based      |
// |               reference model, directed vectors and random traffic.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_swnet_ctrl;

   localparam int QDEPTH = 4;
   localparam int TO     = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        valid;
   logic [15:0] wdata, waddr;
   logic        wfull;
   logic        core_stall, ni_winc, err_timeout;
   logic [15:0] ni_wdata, ni_waddr, stall_cnt;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mq[$];
   logic [31:0] delivered[$];
   int          m_blk   = 0;
   int          m_stall = 0;
   bit          m_err   = 1'b0;

   typedef struct {
      bit          rn;
      bit          v;
      logic [15:0] a;
      logic [15:0] d;
      bit          wf;
      bit          e_stall;
      bit          e_winc;
      logic [15:0] e_a;
      logic [15:0] e_d;
   } vec_t;

   vec_t vecs[6];

   swnet_ctrl #(.MSB_SLOT(5), .QADDR(2), .TIMEOUT(TO)) dut (
      .clk_i              (clk),
      .reset_ni           (reset_n),
      .core_swnet_valid_i (valid),
      .core_wdata_i       (wdata),
      .core_waddr_i       (waddr),
      .core_stall_o       (core_stall),
      .ni_wfull_i         (wfull),
      .ni_winc_o          (ni_winc),
      .ni_wdata_o         (ni_wdata),
      .ni_waddr_o         (ni_waddr),
      .stall_cnt_o        (stall_cnt),
      .err_timeout_o      (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs and compare every output against the model.
   task automatic apply(input bit rn, input bit v, input logic [15:0] a,
                        input logic [15:0] d, input bit wf);
      int          sz;
      logic [31:0] head;
      reset_n = rn; valid = v; waddr = a; wdata = d; wfull = wf;
      #1;
      sz   = mq.size();
      head = (sz > 0) ? mq[0] : 32'h0;
      chk("core_stall", {31'd0, core_stall}, {31'd0, (v && sz == QDEPTH)});
      chk("ni_winc",    {31'd0, ni_winc},    {31'd0, (sz > 0 && !wf)});
      chk("ni_waddr",   {16'd0, ni_waddr},   {16'd0, head[31:16]});
      chk("ni_wdata",   {16'd0, ni_wdata},   {16'd0, head[15:0]});
      chk("stall_cnt",  {16'd0, stall_cnt},  m_stall);
      chk("err_timeout",{31'd0, err_timeout},{31'd0, m_err});
      if (ni_winc === 1'b1) delivered.push_back({ni_waddr, ni_wdata});
   endtask

   // Clock edge, then advance the reference model using the driven inputs.
   task automatic advance();
      int sz;
      bit blocked, stall;
      sz = mq.size();
      @(posedge clk);
      #2;
      if (!reset_n) begin
         mq.delete();
         m_blk = 0; m_stall = 0; m_err = 1'b0;
      end else begin
         blocked = (sz > 0) && wfull;
         stall   = valid && (sz == QDEPTH);
         if (sz > 0 && !wfull) void'(mq.pop_front());
         if (valid && sz < QDEPTH) mq.push_back({waddr, wdata});
         m_blk = blocked ? ((m_blk < 65535) ? m_blk + 1 : m_blk) : 0;
         if (blocked && m_blk == TO) m_err = 1'b1;
         if (stall && m_stall < 65535) m_stall++;
      end
   endtask

   task automatic cycle(input bit rn, input bit v, input logic [15:0] a,
                        input logic [15:0] d, input bit wf);
      apply(rn, v, a, d, wf);
      advance();
   endtask

   initial begin
      bit pend;
      bit st;
      logic [31:0] sent[$];

      vecs[0] = '{1'b0, 1'b1, 16'h0012, 16'hABCD, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
      vecs[1] = '{1'b0, 1'b1, 16'h0012, 16'hABCD, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
      vecs[2] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
      vecs[3] = '{1'b1, 1'b1, 16'h0012, 16'hABCD, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
      vecs[4] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0012, 16'hABCD};
      vecs[5] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};

      reset_n = 1'b0; valid = 1'b0; waddr = '0; wdata = '0; wfull = 1'b0;
      @(posedge clk);
      #2;

      // Reset with a request present, then a single store.
      for (int i = 0; i < 6; i++) begin
         apply(vecs[i].rn, vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].wf);
         chk($sformatf("vec%0d_stall", i), {31'd0, core_stall}, {31'd0, vecs[i].e_stall});
         chk($sformatf("vec%0d_winc", i),  {31'd0, ni_winc},    {31'd0, vecs[i].e_winc});
         chk($sformatf("vec%0d_waddr", i), {16'd0, ni_waddr},   {16'd0, vecs[i].e_a});
         chk($sformatf("vec%0d_wdata", i), {16'd0, ni_wdata},   {16'd0, vecs[i].e_d});
         advance();
      end

      // Fill while NI is full, stall the fifth request, then drain.
      cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      delivered.delete();
      for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, 16'h0100 + 16'(i), 16'(i), 1'b1);
      for (int h = 0; h < 3; h++) begin
         apply(1'b1, 1'b1, 16'h0105, 16'd5, 1'b1);
         chk("stall_fifth", {31'd0, core_stall}, 32'd1);
         advance();
      end
      chk("stall_cnt_held", {16'd0, stall_cnt}, 32'd3);
      pend = 1'b1;
      for (int c = 0; c < 7; c++) begin
         apply(1'b1, pend, 16'h0105, 16'd5, 1'b0);
         st = core_stall;
         advance();
         if (!st) pend = 1'b0;
      end
      chk("fill_deliv_count", delivered.size(), 32'd5);
      for (int i = 0; i < 5 && i < delivered.size(); i++)
         chk($sformatf("fill_order%0d", i), delivered[i], {16'h0100 + 16'(i + 1), 16'(i + 1)});
      chk("stall_cnt_final", {16'd0, stall_cnt}, 32'd4);

      // Timeout: one entry blocked for TO edges.
      cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      cycle(1'b1, 1'b1, 16'h0077, 16'h5555, 1'b1);
      for (int k = 1; k <= TO; k++) begin
         cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b1);
         chk($sformatf("timeout_edge%0d", k), {31'd0, err_timeout}, (k == TO) ? 32'd1 : 32'd0);
      end
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
      chk("timeout_sticky", {31'd0, err_timeout}, 32'd1);

      // Reset discards queued entries.
      cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 16'h0200 + 16'(i), 16'h1000 + 16'(i), 1'b1);
      cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
         chk("post_reset_winc", {31'd0, ni_winc}, 32'd0);
         advance();
      end
      chk("post_reset_err", {31'd0, err_timeout}, 32'd0);

      // Continuous traffic across pointer wrap.
      delivered.delete();
      for (int i = 0; i < 20; i++) begin
         sent.push_back({16'h0300 + 16'(i), 16'hC000 + 16'(i * 7)});
         apply(1'b1, 1'b1, 16'h0300 + 16'(i), 16'hC000 + 16'(i * 7), 1'b0);
         if (i > 0) chk("stream_winc", {31'd0, ni_winc}, 32'd1);
         advance();
      end
      for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
      chk("stream_count", delivered.size(), 32'd20);
      for (int i = 0; i < 20 && i < delivered.size(); i++)
         chk($sformatf("stream_order%0d", i), delivered[i], sent[i]);

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) < 6),
               16'($urandom), 16'($urandom), ($urandom_range(0, 9) < 4));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
